// File: rtl/fetch_queue_pkg.sv
// pipeline_pkg: definitions shared by the fetch stage and later pipeline stages.
//   XLEN / INSTR_WIDTH    - address and instruction word widths
//   RESET_VECTOR_DEFAULT  - default pc after reset
//   redirect_cause_t      - redirect cause encoding (writeback uses the same values)
//   fetch_entry_t         - one buffered fetch result {pc, instr}
//   redirect_cause()      - resolves simultaneous redirects, trap > mret > branch
package pipeline_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_WIDTH = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_BRANCH = 2'd1,
    CAUSE_MRET   = 2'd2,
    CAUSE_TRAP   = 2'd3
  } redirect_cause_t;

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  function automatic redirect_cause_t redirect_cause(input logic trap,
                                                    input logic mret,
                                                    input logic branch);
    redirect_cause_t cause;
    if (trap)        cause = CAUSE_TRAP;
    else if (mret)   cause = CAUSE_MRET;
    else if (branch) cause = CAUSE_BRANCH;
    else             cause = CAUSE_NONE;
    return cause;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_bus_if: pipelined instruction read bus (request/grant/response).
//   fetch_req      master->slave  request valid
//   fetch_address  master->slave  request word address
//   fetch_gnt      slave->master  request accepted this cycle
//   fetch_rvalid   slave->master  response valid, responses return in request order
//   fetch_data     slave->master  response word
interface fetch_bus_if;
  import pipeline_pkg::*;

  logic                   fetch_req;
  logic [XLEN-1:0]        fetch_address;
  logic                   fetch_gnt;
  logic                   fetch_rvalid;
  logic [INSTR_WIDTH-1:0] fetch_data;

  modport master (
    output fetch_req,
    output fetch_address,
    input  fetch_gnt,
    input  fetch_rvalid,
    input  fetch_data
  );

  modport slave (
    input  fetch_req,
    input  fetch_address,
    output fetch_gnt,
    output fetch_rvalid,
    output fetch_data
  );

endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// sync_fifo: single-clock in-order FIFO with synchronous flush.
//   clk, reset (async, active-low)
//   flush      - empties the FIFO, overrides push/pop
//   push/push_data - write one entry (ignored when full and not popping)
//   pop        - remove head entry (ignored when empty)
//   head       - current head entry (valid when count != 0)
//   count      - number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty && !flush;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || do_pop);

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: pipelined instruction fetch stage with an in-order result queue.
//   clk, reset (async, active-low)
//   trap/mret/branch + *_vector - redirect requests and targets (trap > mret > branch)
//   stall       - hold the decode output registers and the queue head
//   invalidate  - clear the decode slot instead of popping
//   bus         - fetch_bus_if master: request/grant/in-order response
//   pc_out, next_pc_out, instruction_out, valid_out - decode-facing registers
// Up to DEPTH requests are outstanding; credit counts queued plus in-flight
// words so a returning response always has a queue slot.
module fetch_queue
  import pipeline_pkg::*;
#(
  parameter int              DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   branch,
  input  logic                   trap,
  input  logic                   mret,
  input  logic [XLEN-1:0]        branch_vector,
  input  logic [XLEN-1:0]        trap_vector,
  input  logic [XLEN-1:0]        mret_vector,
  input  logic                   stall,
  input  logic                   invalidate,
  fetch_bus_if.master            bus,
  output logic [XLEN-1:0]        pc_out,
  output logic [XLEN-1:0]        next_pc_out,
  output logic [INSTR_WIDTH-1:0] instruction_out,
  output logic                   valid_out
);

  localparam int            CW           = $clog2(DEPTH + 1);
  localparam logic [CW:0]   CREDIT_LIMIT = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(4);

  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] resp_pc_reg, resp_pc_next;
  logic [CW-1:0]   inflight_reg, inflight_next;
  logic [CW-1:0]   drop_reg, drop_next;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;

  redirect_cause_t cause;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;

  logic            fetch_req;
  logic            issue;
  logic            answered;
  logic            keep;
  logic            pop;
  logic            queue_empty;

  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;
  logic [$bits(fetch_entry_t)-1:0] head_bits;

  // ---------------- redirect selection ----------------
  assign cause    = redirect_cause(trap, mret, branch);
  assign redirect = (cause != CAUSE_NONE);

  always_comb begin
    redirect_target = branch_vector;
    case (cause)
      CAUSE_TRAP:   redirect_target = trap_vector;
      CAUSE_MRET:   redirect_target = mret_vector;
      CAUSE_BRANCH: redirect_target = branch_vector;
      default:      redirect_target = branch_vector;
    endcase
  end

  // ---------------- request credit ----------------
  // Built only from registered state so the request never sees redirect inputs.
  assign occupancy         = {1'b0, count} + {1'b0, inflight_reg};
  assign fetch_req         = (occupancy < CREDIT_LIMIT);
  assign issue             = fetch_req && bus.fetch_gnt;
  assign bus.fetch_req     = fetch_req;
  assign bus.fetch_address = pc_reg;

  // ---------------- response accounting ----------------
  // A response with nothing outstanding (only possible right after reset)
  // must not wrap the counter.
  assign answered = bus.fetch_rvalid && (inflight_reg != '0);

  always_comb begin
    case ({issue, answered})
      2'b10:   inflight_next = inflight_reg + CW'(1);
      2'b01:   inflight_next = inflight_reg - CW'(1);
      default: inflight_next = inflight_reg;
    endcase
  end

  // On a redirect everything still outstanding (including a request granted
  // in the same cycle) is stale; otherwise each response eats one drop credit.
  always_comb begin
    drop_next = drop_reg;
    if (redirect) begin
      drop_next = inflight_next;
    end else if (bus.fetch_rvalid && (drop_reg != '0)) begin
      drop_next = drop_reg - CW'(1);
    end
  end

  assign keep = bus.fetch_rvalid && (drop_reg == '0) && !redirect;

  // ---------------- address tracking ----------------
  always_comb begin
    pc_next      = pc_reg;
    resp_pc_next = resp_pc_reg;
    if (redirect) begin
      pc_next      = redirect_target;
      resp_pc_next = redirect_target;
    end else begin
      if (issue) pc_next      = pc_reg + WORD_BYTES;
      if (keep)  resp_pc_next = resp_pc_reg + WORD_BYTES;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg       <= RESET_VECTOR;
      resp_pc_reg  <= RESET_VECTOR;
      inflight_reg <= '0;
      drop_reg     <= '0;
    end else begin
      pc_reg       <= pc_next;
      resp_pc_reg  <= resp_pc_next;
      inflight_reg <= inflight_next;
      drop_reg     <= drop_next;
    end
  end

  // ---------------- instruction queue ----------------
  assign push_entry.pc    = resp_pc_reg;
  assign push_entry.instr = bus.fetch_data;

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (keep),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_bits),
    .count     (count)
  );

  assign head_entry  = head_bits;
  assign queue_empty = (count == '0);
  assign pop         = !stall && !invalidate && !redirect && !queue_empty;

  // ---------------- decode output registers ----------------
  // Only valid_out is cleared when nothing is popped; the rest hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_out          <= '0;
      next_pc_out     <= '0;
      instruction_out <= '0;
      valid_out       <= 1'b0;
    end else if (!stall) begin
      if (pop) begin
        pc_out          <= head_entry.pc;
        next_pc_out     <= head_entry.pc + WORD_BYTES;
        instruction_out <= head_entry.instr;
        valid_out       <= 1'b1;
      end else begin
        valid_out       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue. A queue-level reference model (pending
// request list with stale marks, result queue, decode slot) predicts every
// output each cycle; the bench also plays the bus slave.
module tb_fetch_queue;
  import pipeline_pkg::*;

  localparam int          DEPTH        = 4;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        branch, trap, mret;
  logic [31:0] branch_vector, trap_vector, mret_vector;
  logic        stall, invalidate;
  logic [31:0] pc_out, next_pc_out, instruction_out;
  logic        valid_out;

  fetch_bus_if bus();

  fetch_queue #(
    .DEPTH        (DEPTH),
    .RESET_VECTOR (RESET_VECTOR)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .branch          (branch),
    .trap            (trap),
    .mret            (mret),
    .branch_vector   (branch_vector),
    .trap_vector     (trap_vector),
    .mret_vector     (mret_vector),
    .stall           (stall),
    .invalidate      (invalidate),
    .bus             (bus),
    .pc_out          (pc_out),
    .next_pc_out     (next_pc_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {logic [31:0] addr; bit stale;} req_t;
  typedef struct {logic [31:0] addr; logic [31:0] data;} ent_t;

  req_t        pend[$];    // accepted, unanswered requests
  ent_t        fq[$];      // kept results awaiting decode
  logic [31:0] bus_q[$];   // slave side: addresses it still owes an answer
  logic        m_valid;
  logic [31:0] m_pc, m_next, m_instr, m_req_pc;
  int          resp_pct;
  int          n_cmp, n_fail;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[17:2]};
  endfunction

  function automatic logic [129:0] exp_vec();
    logic req;
    req = (fq.size() + pend.size()) < DEPTH;
    return {m_valid, m_pc, m_next, m_instr, req, req ? m_req_pc : 32'h0};
  endfunction

  function automatic logic [129:0] obs_vec();
    return {valid_out, pc_out, next_pc_out, instruction_out, bus.fetch_req,
            bus.fetch_req ? bus.fetch_address : 32'h0};
  endfunction

  task automatic reset_model();
    pend.delete();
    fq.delete();
    bus_q.delete();
    m_valid  = 1'b0;
    m_pc     = 32'h0;
    m_next   = 32'h0;
    m_instr  = 32'h0;
    m_req_pc = RESET_VECTOR;
  endtask

  task automatic clear_inputs();
    branch = 0; trap = 0; mret = 0;
    branch_vector = 0; trap_vector = 0; mret_vector = 0;
    stall = 0; invalidate = 0;
    bus.fetch_gnt = 0; bus.fetch_rvalid = 0; bus.fetch_data = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    reset_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // One clock: advance the model with this cycle's inputs, let the DUT take
  // the edge, then choose the slave's response for the next cycle.
  task automatic tick();
    bit          redir, req_m;
    logic [31:0] vec;
    req_t        r;
    ent_t        e;
    redir = trap || mret || branch;
    vec   = trap ? trap_vector : (mret ? mret_vector : branch_vector);
    req_m = (fq.size() + pend.size()) < DEPTH;
    if (bus.fetch_req === 1'b1 && bus.fetch_gnt) bus_q.push_back(bus.fetch_address);
    if (!stall) begin
      if (invalidate || redir || fq.size() == 0) begin
        m_valid = 1'b0;
      end else begin
        e       = fq.pop_front();
        m_valid = 1'b1;
        m_pc    = e.addr;
        m_next  = e.addr + 32'd4;
        m_instr = e.data;
      end
    end
    if (bus.fetch_rvalid && pend.size() > 0) begin
      r = pend.pop_front();
      if (!r.stale && !redir) fq.push_back('{addr: r.addr, data: mem_word(r.addr)});
    end
    if (req_m && bus.fetch_gnt) begin
      pend.push_back('{addr: m_req_pc, stale: redir});
      m_req_pc = m_req_pc + 32'd4;
    end
    if (redir) begin
      m_req_pc = vec;
      foreach (pend[i]) pend[i].stale = 1'b1;
      fq.delete();
    end
    @(posedge clk);
    #1;
    if (bus_q.size() > 0 && $urandom_range(99) < resp_pct) begin
      bus.fetch_rvalid = 1'b1;
      bus.fetch_data   = mem_word(bus_q.pop_front());
    end else begin
      bus.fetch_rvalid = 1'b0;
      bus.fetch_data   = $urandom;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    reset_model();
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({valid_out, pc_out, next_pc_out, instruction_out} !== 97'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", {valid_out, pc_out, next_pc_out, instruction_out});
    end
    @(posedge clk);
    #1 reset = 1'b1;
    n_cmp++;
    if (bus.fetch_req !== 1'b1 || bus.fetch_address !== RESET_VECTOR) begin
      n_fail++;
      $display("FAIL reset_request: got req=%b addr=%h want req=1 addr=%h",
               bus.fetch_req, bus.fetch_address, RESET_VECTOR);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_sequential();
    logic [31:0] seen_pc[$];
    logic [31:0] seen_next[$];
    do_reset();
    bus.fetch_gnt = 1'b1;
    resp_pct = 100;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL sequential cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (valid_out === 1'b1) begin
        seen_pc.push_back(pc_out);
        seen_next.push_back(next_pc_out);
      end
    end
    n_cmp++;
    if (seen_pc.size() < 3) begin
      n_fail++;
      $display("FAIL sequential_count: got %0d deliveries want >=3", seen_pc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (seen_pc[i] !== 32'(4 * i) || seen_next[i] !== 32'(4 * i + 4)) begin
          n_fail++;
          $display("FAIL sequential_order %0d: got pc=%h next=%h want pc=%h next=%h",
                   i, seen_pc[i], seen_next[i], 32'(4 * i), 32'(4 * i + 4));
        end
      end
    end
  endtask

  task automatic test_credit_stall();
    int          grants;
    logic [31:0] seen[$];
    do_reset();
    stall = 1'b1;
    bus.fetch_gnt = 1'b1;
    resp_pct = 100;
    grants = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.fetch_req === 1'b1) grants++;
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL credit_fill cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (grants !== DEPTH || bus.fetch_req !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_limit: got grants=%0d req=%b want grants=%0d req=0",
               grants, bus.fetch_req, DEPTH);
    end
    stall = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL credit_drain cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (valid_out === 1'b1) seen.push_back(pc_out);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= seen.size() || seen[i] !== 32'(4 * i)) begin
        n_fail++;
        $display("FAIL credit_order %0d: got %h want %h", i,
                 (i < seen.size()) ? seen[i] : 32'hx, 32'(4 * i));
      end
    end
  endtask

  task automatic test_branch_flush();
    bit          found;
    logic [31:0] first_pc;
    do_reset();
    bus.fetch_gnt = 1'b1;
    resp_pct = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL branch_setup cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    bus.fetch_gnt = 1'b0;
    branch = 1'b1;
    branch_vector = 32'h0000_0100;
    tick();
    branch = 1'b0;
    n_cmp++;
    if (bus.fetch_address !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL branch_target: got %h want 00000100", bus.fetch_address);
    end
    bus.fetch_gnt = 1'b1;
    resp_pct = 100;
    found = 0;
    first_pc = 32'h0;
    for (int c = 0; c < 15; c++) begin
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL branch_run cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (!found && valid_out === 1'b1) begin
        found = 1;
        first_pc = pc_out;
      end
    end
    n_cmp++;
    if (!found || first_pc !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL branch_first: got found=%0d pc=%h want pc=00000100", found, first_pc);
    end
  endtask

  task automatic test_priority();
    bit          found;
    logic [31:0] first_pc;
    do_reset();
    bus.fetch_gnt = 1'b1;
    resp_pct = 100;
    repeat (4) tick();
    trap = 1; mret = 1; branch = 1;
    trap_vector = 32'h0000_2000; mret_vector = 32'h0000_3000; branch_vector = 32'h0000_4000;
    tick();
    trap = 0; mret = 0; branch = 0;
    n_cmp++;
    if (bus.fetch_address !== 32'h0000_2000) begin
      n_fail++;
      $display("FAIL priority_target: got %h want 00002000", bus.fetch_address);
    end
    found = 0;
    first_pc = 32'h0;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL priority_run cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (!found && valid_out === 1'b1) begin
        found = 1;
        first_pc = pc_out;
      end
    end
    n_cmp++;
    if (!found || first_pc !== 32'h0000_2000) begin
      n_fail++;
      $display("FAIL priority_first: got found=%0d pc=%h want pc=00002000", found, first_pc);
    end
  endtask

  task automatic test_stall_hold();
    logic [96:0] cap;
    logic [31:0] prev;
    do_reset();
    bus.fetch_gnt = 1'b1;
    resp_pct = 100;
    repeat (6) tick();
    cap = {valid_out, pc_out, next_pc_out, instruction_out};
    n_cmp++;
    if (valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_precondition: got valid=%b want 1", valid_out);
    end
    stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if ({valid_out, pc_out, next_pc_out, instruction_out} !== cap ||
          obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL stall_hold cyc %0d: got %h want %h (model %h)", c,
                 {valid_out, pc_out, next_pc_out, instruction_out}, cap, exp_vec());
      end
    end
    stall = 1'b0;
    prev = cap[95:64];
    for (int c = 0; c < 8; c++) begin
      tick();
      if (valid_out === 1'b1) begin
        n_cmp++;
        if (pc_out !== prev + 32'd4 || obs_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL stall_release cyc %0d: got pc=%h want pc=%h", c, pc_out, prev + 32'd4);
        end
        prev = pc_out;
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.fetch_gnt = 1'b1;
    resp_pct = 100;
    repeat (6) tick();
    #3 reset = 1'b0;
    bus.fetch_rvalid = 1'b0;
    reset_model();
    #1;
    n_cmp++;
    if ({valid_out, pc_out, next_pc_out, instruction_out} !== 97'h0 ||
        bus.fetch_address !== RESET_VECTOR) begin
      n_fail++;
      $display("FAIL async_reset: got out=%h addr=%h want out=0 addr=%h",
               {valid_out, pc_out, next_pc_out, instruction_out}, bus.fetch_address, RESET_VECTOR);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    n_cmp++;
    if (bus.fetch_req !== 1'b1 || bus.fetch_address !== RESET_VECTOR) begin
      n_fail++;
      $display("FAIL async_first_fetch: got req=%b addr=%h want req=1 addr=%h",
               bus.fetch_req, bus.fetch_address, RESET_VECTOR);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL async_resume cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int delivered;
    do_reset();
    resp_pct = 60;
    delivered = 0;
    for (int c = 0; c < 1500; c++) begin
      bus.fetch_gnt = ($urandom_range(99) < 70);
      stall         = ($urandom_range(99) < 20);
      invalidate    = ($urandom_range(99) < 10);
      trap          = ($urandom_range(99) < 1);
      mret          = ($urandom_range(99) < 1);
      branch        = ($urandom_range(99) < 3);
      trap_vector   = $urandom & 32'hFFFF_FFFC;
      mret_vector   = $urandom & 32'hFFFF_FFFC;
      branch_vector = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(3) << 2))
                                               : ($urandom & 32'hFFFF_FFFC);
      if (!stall && valid_out === 1'b1) delivered++;
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    clear_inputs();
    n_cmp++;
    if (delivered < 100) begin
      n_fail++;
      $display("FAIL random_progress: got %0d deliveries want >=100", delivered);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    resp_pct = 100;
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_credit_stall();
    test_branch_flush();
    test_priority();
    test_stall_hold();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
